// File: rtl/pcileech_com_pkg.sv
// Shared types and constants for the COM receive packer.
package pcileech_com_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } com_state_t;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'h66665555;
  localparam int unsigned CNT_W             = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pcileech_com_rxpack_if.sv
// Inbound 32-bit stream and outbound packed-word stream of the COM receive packer.
interface pcileech_com_rxpack_if #(
  parameter int unsigned WORDS = 2
);
  logic [31:0]         in_data;
  logic                in_valid;
  logic                in_ready;
  logic [WORDS*32-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/pcileech_com_sfifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit.
module pcileech_com_sfifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so push into a full FIFO still lands
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pcileech_com_rxpack.sv
// COM receive packer: boot-word injection, 32-bit lane packing with
// double-marker resync, and an output FIFO.
module pcileech_com_rxpack
  import pcileech_com_pkg::*;
#(
  parameter int unsigned WORDS      = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INIT_DEPTH = 5,
  parameter int unsigned INIT_DELAY = 16,
  parameter logic [31:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [((INIT_DEPTH > 0) ? INIT_DEPTH : 1)*WORDS*32-1:0] init_words,
  pcileech_com_rxpack_if.slave    bus,
  output logic [1:0]              state,
  output logic [CNT_W-1:0]        resync_cnt,
  output logic [CNT_W-1:0]        drop_cnt
);
  localparam int unsigned WW     = WORDS * 32;
  localparam int unsigned IDEP   = (INIT_DEPTH > 0) ? INIT_DEPTH : 1;
  localparam int unsigned IDX_W  = (IDEP > 1) ? $clog2(IDEP) : 1;
  localparam int unsigned DLY_W  = $clog2(INIT_DELAY + 2);
  localparam int unsigned LANE_W = $clog2(WORDS);

  com_state_t        st;
  logic [DLY_W-1:0]  dly_cnt;
  logic [IDX_W-1:0]  init_idx;
  logic [LANE_W-1:0] lane;
  logic [31:0]       prev_word;
  logic [WW-1:0]     pack;
  logic              pack_push;

  logic [WW-1:0]     init_arr [IDEP];
  logic [WW-1:0]     init_word;
  logic              init_zero;
  logic              init_step;
  logic              init_push;
  logic              delay_done;
  logic              fifo_full;
  logic              fifo_empty;
  logic              in_ready;
  logic              accept;
  logic              resync;

  for (genvar k = 0; k < IDEP; k++) begin : g_init
    assign init_arr[k] = init_words[k*WW +: WW];
  end

  assign init_word  = init_arr[init_idx];
  assign init_zero  = (init_word == '0);
  // zero words are skipped even while the FIFO is full
  assign init_step  = (st == ST_INIT) && (init_zero || !fifo_full);
  assign init_push  = (st == ST_INIT) && !init_zero && !fifo_full;
  assign delay_done = (32'(dly_cnt) + 32'd1) >= INIT_DELAY;

  assign in_ready     = (st == ST_RUN) && !fifo_full;
  assign accept       = bus.in_valid && in_ready;
  assign resync       = (bus.in_data == SYNC_WORD) && (prev_word == SYNC_WORD);
  assign bus.in_ready = in_ready;
  assign bus.out_valid = !fifo_empty;
  assign state        = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_WAIT;
      dly_cnt    <= '0;
      init_idx   <= '0;
      lane       <= '0;
      prev_word  <= '0;
      pack       <= '0;
      pack_push  <= 1'b0;
      resync_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      pack_push <= 1'b0;

      case (st)
        ST_WAIT: begin
          dly_cnt <= dly_cnt + 1'b1;
          if (delay_done) st <= (INIT_DEPTH == 0) ? ST_RUN : ST_INIT;
        end
        ST_INIT: begin
          if (init_step) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == IDX_W'(INIT_DEPTH - 1)) st <= ST_RUN;
          end
        end
        default: ;
      endcase

      if (bus.in_valid && !in_ready) drop_cnt <= sat_inc(drop_cnt);

      if (accept) begin
        if (resync) begin
          lane       <= '0;
          prev_word  <= '0;
          resync_cnt <= sat_inc(resync_cnt);
        end else begin
          pack      <= {pack[WW-33:0], bus.in_data};
          prev_word <= bus.in_data;
          if (lane == LANE_W'(WORDS - 1)) begin
            lane      <= '0;
            pack_push <= 1'b1;
          end else begin
            lane <= lane + 1'b1;
          end
        end
      end
    end
  end

  // init pushes and pack pushes never overlap: pack pushes only follow RUN-state accepts
  pcileech_com_sfifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (init_push || pack_push),
    .wdata (pack_push ? pack : init_word),
    .full  (fifo_full),
    .pop   (bus.out_ready),
    .rdata (bus.out_data),
    .empty (fifo_empty)
  );

endmodule
